seq_access_arbiter: RTL and testbench
=====================================

// Module: seq_access_arbiter
// PURPOSE
// - Clocked, N-user successor to the two-user combinational vehicle-access controller.
// - Validates user codes and checks requested functions against per-level permissions.
// - Arbitrates one function grant at a time: highest level wins, round-robin among equals, each grant held for a minimum time.
// - Handles autopilot entry after a period with no valid user, and drives a scanned 4-digit 7-segment display.
// PARAMETERS
// N_USERS       4        number of user channels (2..8)
// HOLD_CYCLES   1000     minimum cycles a grant is held before re-arbitration (>=1)
// AUTO_TIMEOUT  5000     consecutive cycles with no valid user before entering AUTO (>=1)
// SCAN_DIV      2500     clock cycles per display digit (>=1)
// PERM_MASK     24'h...  8 bits per level 1..3 (level L uses bits [8L-1:8L-8]); bit k set = function k permitted
// PORTS
// CLK      in   1           system clock, all state on rising edge
// RST      in   1           asynchronous, active-high reset
// U        in   3*N_USERS   user code per channel, channel i = U[3i+2:3i]
// F        in   3*N_USERS   requested function id per channel (0 = no request)
// GRANT    out  N_USERS     one-hot granted channel, all-zero when none
// ACT_FUNC out  3           function id being executed (0 when none)
// DENIED   out  N_USERS     1-cycle pulse: valid user requested a non-permitted function
// LED_RGB  out  3           {R,G,B}: IDLE=001, GRANT=010, AUTO=100
// SEG      out  7           segments a..g, active-low
// DIG      out  4           digit enables, active-low, one low at a time
// DP       out  1           decimal point, active-low
// BEHAVIOUR
// - Clock/reset: single clock CLK; RST is asynchronous and active-high.
// - Reset values: state=IDLE, GRANT=0, ACT_FUNC=0, DENIED=0, LED_RGB=001, DIG=1110, SEG=7'h7F, DP=1.
//   All counters and the round-robin pointer clear to 0.
// - Input stage: U and F are registered every cycle. All decisions use the registered copy.
// - Request to GRANT latency is exactly 2 cycles.
// - Level decode: U=001 -> level 1, 010 -> level 2, 100 -> level 3. Any other code is invalid (level 0).
// - Eligible channel: valid, F!=0, and PERM_MASK bit for (level, F) is set.
// - Valid, F!=0, not permitted: DENIED[i] pulses for one cycle on each 0->1 transition of that condition, not continuously.
// - Winner: eligible channel with the highest level. Ties go to the first index >= rr_ptr, modulo N_USERS.
// - FSM IDLE:
//   - If any channel is eligible -> GRANT (winner latched, hold_cnt=0).
//   - Else if no channel is valid for AUTO_TIMEOUT consecutive cycles -> AUTO.
// - FSM GRANT:
//   - GRANT/ACT_FUNC are driven from the latched winner; hold_cnt increments each cycle.
//   - Withdrawal: winner becomes ineligible -> release next cycle; go to GRANT with a new winner if any, else IDLE.
//   - Preemption: an eligible channel with a strictly higher level appears -> switch directly next cycle, hold_cnt=0.
//   - Hold expiry at hold_cnt==HOLD_CYCLES-1: rr_ptr = winner+1 (wraps to 0 after N_USERS-1), then re-arbitrate.
//   - An F change on the winner channel that is still permitted updates ACT_FUNC without re-arbitration.
// - FSM AUTO: LED_RGB=100, GRANT=0. Any channel becoming valid (not necessarily eligible) -> IDLE next cycle.
// - Timeout counter: increments only while no channel is valid. It clears on any valid channel and saturates at AUTO_TIMEOUT.
// - Display scan:
//   - Prescaler counts 0..SCAN_DIV-1; digit index advances 0->1->2->3->0 on wrap.
//   - In GRANT, digits 3..0 show "U", winner index, "F", ACT_FUNC. IDLE shows "----". AUTO shows "A" "U" "t" "o".
//   - DP is lit on digit 0 only while in AUTO.
// - Simultaneous events: preemption beats hold expiry, and hold expiry beats an F update. RST mid-grant drops GRANT immediately (async).
// STRUCTURE
// - Shared package access_pkg:
//   - FSM state encoding (IDLE, GRANT, AUTO).
//   - User code constants, level width (2 bits).
//   - 7-segment glyph constants (hex digits, U, F, A, t, o, dash).
// - One sub-module: seg_scan_driver. Owns the prescaler, digit counter and glyph mux, and takes four 5-bit glyph codes plus a DP mask.
// - Arbitration (level compare, round-robin search) stays inline as combinational logic.
// TESTING
// - Reset then idle with all U=000: LED_RGB=001, DIG cycles 1110->1101->1011->0111 every SCAN_DIV cycles.
//   After AUTO_TIMEOUT cycles LED_RGB=100 and the display shows "AUtO".
// - Single request U[0]=001, F[0]=1 (permitted): GRANT=0001 and ACT_FUNC=1 exactly 2 cycles after the inputs change.
//   U[0]=011 instead: no grant; after AUTO_TIMEOUT the block enters AUTO.
// - Equal levels: ch0 and ch2 both U=010, F=2. Grants alternate 0001 -> 0100 -> 0001, each held HOLD_CYCLES cycles.
// - Preemption: ch1 (level1) granted, ch3 goes level3 eligible mid-hold. GRANT=1000 within 2 cycles, hold restarts.
// - Denial: level-1 user requests a function with a clear PERM_MASK bit. DENIED pulses exactly 1 cycle and GRANT stays 0.
//   Any valid user during AUTO returns the block to IDLE next cycle.
// - Async RST asserted mid-grant, between clock edges: GRANT=0 and LED_RGB=001 before the next CLK edge.

Source files
------------

// File: rtl/access_pkg.sv
// Shared definitions for the sequential access arbiter: FSM encoding,
// user codes, level decode, permission lookup and 7-segment glyphs.
package access_pkg;

    localparam int LEVEL_W = 2;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [4:0]         glyph_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_AUTO  = 2'd2;

    localparam logic [2:0] UCODE_L1 = 3'b001;
    localparam logic [2:0] UCODE_L2 = 3'b010;
    localparam logic [2:0] UCODE_L3 = 3'b100;

    // Glyph codes 0..15 are the hex digits themselves
    localparam glyph_t GLY_U     = 5'd16;
    localparam glyph_t GLY_F     = 5'd17;
    localparam glyph_t GLY_A     = 5'd18;
    localparam glyph_t GLY_T     = 5'd19;
    localparam glyph_t GLY_O     = 5'd20;
    localparam glyph_t GLY_DASH  = 5'd21;
    localparam glyph_t GLY_BLANK = 5'd22;

    function automatic level_t levelOf(input logic [2:0] code);
        case (code)
            UCODE_L1: return 2'd1;
            UCODE_L2: return 2'd2;
            UCODE_L3: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic isPermitted(input logic [23:0] mask, input level_t lvl,
                                         input logic [2:0] fn);
        logic [7:0] row;
        case (lvl)
            2'd1:    row = mask[7:0];
            2'd2:    row = mask[15:8];
            2'd3:    row = mask[23:16];
            default: row = 8'h00;
        endcase
        return row[fn];
    endfunction

    // Segment order is {a,b,c,d,e,f,g}; patterns are inverted for active-low drive
    function automatic logic [6:0] glyphToSeg(input glyph_t g);
        logic [6:0] lit;
        case (g)
            5'd0:    lit = 7'h7E;
            5'd1:    lit = 7'h30;
            5'd2:    lit = 7'h6D;
            5'd3:    lit = 7'h79;
            5'd4:    lit = 7'h33;
            5'd5:    lit = 7'h5B;
            5'd6:    lit = 7'h5F;
            5'd7:    lit = 7'h70;
            5'd8:    lit = 7'h7F;
            5'd9:    lit = 7'h7B;
            5'd10:   lit = 7'h77;
            5'd11:   lit = 7'h1F;
            5'd12:   lit = 7'h4E;
            5'd13:   lit = 7'h3D;
            5'd14:   lit = 7'h4F;
            5'd15:   lit = 7'h47;
            GLY_U:   lit = 7'h3E;
            GLY_F:   lit = 7'h47;
            GLY_A:   lit = 7'h77;
            GLY_T:   lit = 7'h0F;
            GLY_O:   lit = 7'h1D;
            GLY_DASH:  lit = 7'h01;
            GLY_BLANK: lit = 7'h00;
            default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Segment, digit and DP outputs are registered together so they never skew.
module seg_scan_driver
    import access_pkg::*;
#(
    parameter int SCAN_DIV = 2500
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  glyph_t     i_glyph3,
    input  glyph_t     i_glyph2,
    input  glyph_t     i_glyph1,
    input  glyph_t     i_glyph0,
    input  logic [3:0] i_dpMask,
    output logic [6:0] o_seg,
    output logic [3:0] o_dig,
    output logic       o_dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [1:0]    r_digIdx;
    logic [6:0]    r_seg;
    logic [3:0]    r_dig;
    logic          r_dp;

    logic          w_wrap;
    logic [1:0]    w_digIdxNext;
    glyph_t        w_glyph;

    assign w_wrap       = (r_pre == PRE_LAST);
    assign w_digIdxNext = w_wrap ? r_digIdx + 2'd1 : r_digIdx;

    always_comb begin
        case (w_digIdxNext)
            2'd0:    w_glyph = i_glyph0;
            2'd1:    w_glyph = i_glyph1;
            2'd2:    w_glyph = i_glyph2;
            default: w_glyph = i_glyph3;
        endcase
    end

    // Outputs follow the digit index that will be current after this edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre    <= '0;
            r_digIdx <= 2'd0;
            r_seg    <= 7'h7F;
            r_dig    <= 4'b1110;
            r_dp     <= 1'b1;
        end else begin
            r_pre    <= w_wrap ? '0 : r_pre + 1'b1;
            r_digIdx <= w_digIdxNext;
            r_seg    <= glyphToSeg(w_glyph);
            r_dig    <= ~(4'b0001 << w_digIdxNext);
            r_dp     <= ~i_dpMask[w_digIdxNext];
        end
    end

    assign o_seg = r_seg;
    assign o_dig = r_dig;
    assign o_dp  = r_dp;

endmodule

// File: rtl/seq_access_arbiter.sv
// N-user vehicle access arbiter: validates user codes, checks per-level
// function permissions and grants one function at a time with a minimum hold.
module seq_access_arbiter
    import access_pkg::*;
#(
    parameter int          N_USERS      = 4,
    parameter int          HOLD_CYCLES  = 1000,
    parameter int          AUTO_TIMEOUT = 5000,
    parameter int          SCAN_DIV     = 2500,
    parameter logic [23:0] PERM_MASK    = 24'hFE1E06
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [3*N_USERS-1:0]   U,
    input  logic [3*N_USERS-1:0]   F,
    output logic [N_USERS-1:0]     GRANT,
    output logic [2:0]             ACT_FUNC,
    output logic [N_USERS-1:0]     DENIED,
    output logic [2:0]             LED_RGB,
    output logic [6:0]             SEG,
    output logic [3:0]             DIG,
    output logic                   DP
);

    localparam int IDX_W  = $clog2(N_USERS);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TMO_W  = $clog2(AUTO_TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_USERS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(AUTO_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);

    logic [3*N_USERS-1:0] r_u;
    logic [3*N_USERS-1:0] r_f;
    logic [1:0]           r_state;
    logic [IDX_W-1:0]     r_winner;
    logic [IDX_W-1:0]     r_rrPtr;
    logic [HOLD_W-1:0]    r_holdCnt;
    logic [2:0]           r_actFunc;
    logic [TMO_W-1:0]     r_tmoCnt;
    logic [N_USERS-1:0]   r_denyPrev;
    logic [N_USERS-1:0]   r_denied;

    logic [1:0]           w_stateNext;
    logic [IDX_W-1:0]     w_winnerNext;
    logic [IDX_W-1:0]     w_rrPtrNext;
    logic [HOLD_W-1:0]    w_holdNext;
    logic [2:0]           w_actNext;

    level_t               w_level [N_USERS];
    logic [2:0]           w_func  [N_USERS];
    logic [N_USERS-1:0]   w_valid;
    logic [N_USERS-1:0]   w_elig;
    logic [N_USERS-1:0]   w_deny;
    logic [N_USERS-1:0]   w_cand;
    level_t               w_maxLevel;
    logic [IDX_W-1:0]     w_win;
    logic [IDX_W-1:0]     w_winExp;
    logic [IDX_W-1:0]     w_rrExp;
    logic                 w_anyValid;
    logic                 w_anyElig;
    logic                 w_tmoHit;
    logic                 w_expire;

    glyph_t               w_glyph3;
    glyph_t               w_glyph2;
    glyph_t               w_glyph1;
    glyph_t               w_glyph0;
    logic [3:0]           w_dpMask;

    // First candidate at or after 'start', wrapping modulo N_USERS
    function automatic logic [IDX_W-1:0] pickWinner(input logic [N_USERS-1:0] cand,
                                                    input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        idx   = start;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < N_USERS; k++) begin
            if (!found && cand[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < N_USERS; gi++) begin : g_chan
        assign w_level[gi] = levelOf(r_u[3*gi +: 3]);
        assign w_func[gi]  = r_f[3*gi +: 3];
        assign w_valid[gi] = (w_level[gi] != 2'd0);
        assign w_elig[gi]  = w_valid[gi] && (w_func[gi] != 3'd0)
                             && isPermitted(PERM_MASK, w_level[gi], w_func[gi]);
        assign w_deny[gi]  = w_valid[gi] && (w_func[gi] != 3'd0)
                             && !isPermitted(PERM_MASK, w_level[gi], w_func[gi]);
        assign w_cand[gi]  = w_elig[gi] && (w_level[gi] == w_maxLevel);
    end

    always_comb begin
        w_maxLevel = 2'd0;
        for (int i = 0; i < N_USERS; i++) begin
            if (w_elig[i] && (w_level[i] > w_maxLevel)) begin
                w_maxLevel = w_level[i];
            end
        end
    end

    assign w_anyValid = |w_valid;
    assign w_anyElig  = |w_elig;
    assign w_tmoHit   = !w_anyValid && (r_tmoCnt >= TMO_LAST);
    assign w_expire   = (r_holdCnt == HOLD_LAST);
    assign w_rrExp    = (r_winner == IDX_LAST) ? '0 : r_winner + 1'b1;
    assign w_win      = pickWinner(w_cand, r_rrPtr);
    assign w_winExp   = pickWinner(w_cand, w_rrExp);

    // Withdrawal, then preemption, then hold expiry, then in-place F update
    always_comb begin
        w_stateNext  = r_state;
        w_winnerNext = r_winner;
        w_rrPtrNext  = r_rrPtr;
        w_holdNext   = r_holdCnt;
        w_actNext    = r_actFunc;
        case (r_state)
            ST_IDLE: begin
                if (w_anyElig) begin
                    w_stateNext  = ST_GRANT;
                    w_winnerNext = w_win;
                    w_holdNext   = '0;
                    w_actNext    = w_func[w_win];
                end else if (w_tmoHit) begin
                    w_stateNext = ST_AUTO;
                end
            end
            ST_GRANT: begin
                if (!w_elig[r_winner]) begin
                    w_holdNext = '0;
                    if (w_anyElig) begin
                        w_winnerNext = w_win;
                        w_actNext    = w_func[w_win];
                    end else begin
                        w_stateNext = ST_IDLE;
                        w_actNext   = 3'd0;
                    end
                end else if (w_maxLevel > w_level[r_winner]) begin
                    w_winnerNext = w_win;
                    w_holdNext   = '0;
                    w_actNext    = w_func[w_win];
                end else if (w_expire) begin
                    w_rrPtrNext  = w_rrExp;
                    w_winnerNext = w_winExp;
                    w_holdNext   = '0;
                    w_actNext    = w_func[w_winExp];
                end else begin
                    w_holdNext = r_holdCnt + 1'b1;
                    w_actNext  = w_func[r_winner];
                end
            end
            ST_AUTO: begin
                if (w_anyValid) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_u        <= '0;
            r_f        <= '0;
            r_state    <= ST_IDLE;
            r_winner   <= '0;
            r_rrPtr    <= '0;
            r_holdCnt  <= '0;
            r_actFunc  <= 3'd0;
            r_tmoCnt   <= '0;
            r_denyPrev <= '0;
            r_denied   <= '0;
        end else begin
            r_u        <= U;
            r_f        <= F;
            r_state    <= w_stateNext;
            r_winner   <= w_winnerNext;
            r_rrPtr    <= w_rrPtrNext;
            r_holdCnt  <= w_holdNext;
            r_actFunc  <= w_actNext;
            r_denyPrev <= w_deny;
            r_denied   <= w_deny & ~r_denyPrev;
            if (w_anyValid) begin
                r_tmoCnt <= '0;
            end else if (r_tmoCnt != TMO_MAX) begin
                r_tmoCnt <= r_tmoCnt + 1'b1;
            end
        end
    end

    assign GRANT    = (r_state == ST_GRANT) ? ({{(N_USERS-1){1'b0}}, 1'b1} << r_winner) : '0;
    assign ACT_FUNC = (r_state == ST_GRANT) ? r_actFunc : 3'd0;
    assign DENIED   = r_denied;

    always_comb begin
        case (r_state)
            ST_GRANT: LED_RGB = 3'b010;
            ST_AUTO:  LED_RGB = 3'b100;
            default:  LED_RGB = 3'b001;
        endcase
    end

    always_comb begin
        w_glyph3 = GLY_DASH;
        w_glyph2 = GLY_DASH;
        w_glyph1 = GLY_DASH;
        w_glyph0 = GLY_DASH;
        w_dpMask = 4'b0000;
        case (r_state)
            ST_GRANT: begin
                w_glyph3 = GLY_U;
                w_glyph2 = 5'(r_winner);
                w_glyph1 = GLY_F;
                w_glyph0 = {2'b00, r_actFunc};
            end
            ST_AUTO: begin
                w_glyph3 = GLY_A;
                w_glyph2 = GLY_U;
                w_glyph1 = GLY_T;
                w_glyph0 = GLY_O;
                w_dpMask = 4'b0001;
            end
            default: begin
            end
        endcase
    end

    seg_scan_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_glyph3 (w_glyph3),
        .i_glyph2 (w_glyph2),
        .i_glyph1 (w_glyph1),
        .i_glyph0 (w_glyph0),
        .i_dpMask (w_dpMask),
        .o_seg    (SEG),
        .o_dig    (DIG),
        .o_dp     (DP)
    );

endmodule

// File: tb/tb_seq_access_arbiter.sv
// Scoreboard bench for seq_access_arbiter with small hold/timeout/scan values.
// Expectations are queued with the cycle they fall due and compared on negedge.
module tb_seq_access_arbiter;

    localparam int NU   = 4;
    localparam int HOLD = 16;
    localparam int TMO  = 40;
    localparam int SDIV = 4;

    localparam int S_GRANT = 0;
    localparam int S_ACT   = 1;
    localparam int S_DEN   = 2;
    localparam int S_LED   = 3;
    localparam int S_SEG   = 4;
    localparam int S_DIG   = 5;
    localparam int S_DP    = 6;

    typedef struct {
        int          due;
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [11:0]   uBus  = '0;
    logic [11:0]   fBus  = '0;
    logic [3:0]    grant;
    logic [2:0]    actFunc;
    logic [3:0]    denied;
    logic [2:0]    ledRgb;
    logic [6:0]    seg;
    logic [3:0]    dig;
    logic          dp;

    int cyc     = 0;
    int nChecks = 0;
    int nErrors = 0;
    int base, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, cr;

    seq_access_arbiter #(
        .N_USERS      (NU),
        .HOLD_CYCLES  (HOLD),
        .AUTO_TIMEOUT (TMO),
        .SCAN_DIV     (SDIV),
        .PERM_MASK    (24'hFE1E06)
    ) dut (
        .CLK      (clock),
        .RST      (reset),
        .U        (uBus),
        .F        (fBus),
        .GRANT    (grant),
        .ACT_FUNC (actFunc),
        .DENIED   (denied),
        .LED_RGB  (ledRgb),
        .SEG      (seg),
        .DIG      (dig),
        .DP       (dp)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [2:0] u, input logic [2:0] f);
        uBus[3*ch +: 3] = u;
        fBus[3*ch +: 3] = f;
    endtask

    task automatic expectAt(input int due, input int sel, input string tag, input logic [31:0] val);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [31:0] sampleOut(input int sel);
        case (sel)
            S_GRANT: return 32'(grant);
            S_ACT:   return 32'(actFunc);
            S_DEN:   return 32'(denied);
            S_LED:   return 32'(ledRgb);
            S_SEG:   return 32'(seg);
            S_DIG:   return 32'(dig);
            default: return 32'(dp);
        endcase
    endfunction

    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checkOutput(sb[i].tag, sampleOut(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_grant",  32'(grant),   32'h0);
        checkOutput("rst_act",    32'(actFunc), 32'h0);
        checkOutput("rst_denied", 32'(denied),  32'h0);
        checkOutput("rst_led",    32'(ledRgb),  32'h1);
        checkOutput("rst_dig",    32'(dig),     32'hE);
        checkOutput("rst_seg",    32'(seg),     32'h7F);
        checkOutput("rst_dp",     32'(dp),      32'h1);
        #20 reset = 1'b0;
        @(posedge clock);
        #1;

        // Idle scan, then autopilot display "AUtO"
        base = cyc;
        expectAt(base + 0,  S_LED, "idle_led",   32'h1);
        expectAt(base + 0,  S_DIG, "scan_d0",    32'hE);
        expectAt(base + 0,  S_SEG, "idle_dash",  32'h7E);
        expectAt(base + 3,  S_DIG, "scan_d1",    32'hD);
        expectAt(base + 7,  S_DIG, "scan_d2",    32'hB);
        expectAt(base + 11, S_DIG, "scan_d3",    32'h7);
        expectAt(base + 15, S_DIG, "scan_wrap",  32'hE);
        expectAt(base + 30, S_LED, "pre_auto",   32'h1);
        expectAt(base + 45, S_LED, "auto_led",   32'h4);
        expectAt(base + 45, S_GRANT, "auto_grant", 32'h0);
        expectAt(base + 47, S_DIG, "auto_dig0",  32'hE);
        expectAt(base + 47, S_SEG, "auto_o",     32'h62);
        expectAt(base + 47, S_DP,  "auto_dp0",   32'h0);
        expectAt(base + 51, S_SEG, "auto_t",     32'h70);
        expectAt(base + 55, S_SEG, "auto_U",     32'h41);
        expectAt(base + 59, S_SEG, "auto_A",     32'h08);
        expectAt(base + 59, S_DIG, "auto_dig3",  32'h7);
        expectAt(base + 59, S_DP,  "auto_dp3",   32'h1);

        // Valid user without request leaves AUTO
        waitUntil(base + 62);
        c1 = cyc;
        applyStimulus(0, 3'b001, 3'd0);
        expectAt(c1 + 1, S_LED, "auto_hold", 32'h4);
        expectAt(c1 + 2, S_LED, "auto_exit", 32'h1);

        // Single permitted request, in-place F update, withdrawal
        waitUntil(c1 + 5);
        c2 = cyc;
        applyStimulus(0, 3'b001, 3'd1);
        expectAt(c2 + 1, S_GRANT, "lat_early", 32'h0);
        expectAt(c2 + 2, S_GRANT, "lat_grant", 32'h1);
        expectAt(c2 + 2, S_ACT,   "lat_act",   32'h1);
        expectAt(c2 + 2, S_LED,   "grant_led", 32'h2);
        waitUntil(c2 + 4);
        applyStimulus(0, 3'b001, 3'd2);
        expectAt(c2 + 5, S_ACT,   "fupd_old",   32'h1);
        expectAt(c2 + 6, S_ACT,   "fupd_new",   32'h2);
        expectAt(c2 + 6, S_GRANT, "fupd_grant", 32'h1);
        waitUntil(c2 + 8);
        c3 = cyc;
        applyStimulus(0, 3'b001, 3'd0);
        expectAt(c3 + 1, S_GRANT, "wd_still", 32'h1);
        expectAt(c3 + 2, S_GRANT, "wd_drop",  32'h0);
        expectAt(c3 + 2, S_ACT,   "wd_act",   32'h0);

        // Invalid user code: no grant, eventually AUTO
        waitUntil(c3 + 4);
        c4 = cyc;
        applyStimulus(0, 3'b011, 3'd1);
        expectAt(c4 + 2,  S_GRANT, "inv_grant",  32'h0);
        expectAt(c4 + 4,  S_GRANT, "inv_grant2", 32'h0);
        expectAt(c4 + 30, S_LED,   "inv_idle",   32'h1);
        expectAt(c4 + 50, S_LED,   "inv_auto",   32'h4);

        // Equal levels alternate on hold expiry
        waitUntil(c4 + 55);
        c5 = cyc;
        applyStimulus(0, 3'b010, 3'd0);
        expectAt(c5 + 2, S_LED, "eq_idle", 32'h1);
        waitUntil(c5 + 5);
        c6 = cyc;
        applyStimulus(0, 3'b010, 3'd2);
        applyStimulus(2, 3'b010, 3'd2);
        expectAt(c6 + 2,  S_GRANT, "rr_first",  32'h1);
        expectAt(c6 + 17, S_GRANT, "rr_hold0",  32'h1);
        expectAt(c6 + 18, S_GRANT, "rr_second", 32'h4);
        expectAt(c6 + 18, S_ACT,   "rr_act",    32'h2);
        expectAt(c6 + 33, S_GRANT, "rr_hold2",  32'h4);
        expectAt(c6 + 34, S_GRANT, "rr_third",  32'h1);

        // Level-1 winner preempted by level-3 request
        waitUntil(c6 + 40);
        c7 = cyc;
        applyStimulus(0, 3'b000, 3'd0);
        applyStimulus(2, 3'b000, 3'd0);
        applyStimulus(1, 3'b001, 3'd1);
        expectAt(c7 + 1, S_GRANT, "sw_old", 32'h1);
        expectAt(c7 + 2, S_GRANT, "sw_ch1", 32'h2);
        expectAt(c7 + 2, S_ACT,   "sw_act", 32'h1);
        waitUntil(c7 + 6);
        c8 = cyc;
        applyStimulus(3, 3'b100, 3'd5);
        expectAt(c8 + 1,  S_GRANT, "pre_before", 32'h2);
        expectAt(c8 + 2,  S_GRANT, "pre_grant",  32'h8);
        expectAt(c8 + 2,  S_ACT,   "pre_act",    32'h5);
        expectAt(c8 + 20, S_GRANT, "pre_keep",   32'h8);

        // Denied function pulses once per rising condition
        waitUntil(c8 + 24);
        c9 = cyc;
        applyStimulus(3, 3'b000, 3'd0);
        applyStimulus(1, 3'b001, 3'd3);
        expectAt(c9 + 1, S_DEN,   "den_early",  32'h0);
        expectAt(c9 + 2, S_DEN,   "den_pulse",  32'h2);
        expectAt(c9 + 2, S_GRANT, "den_grant",  32'h0);
        expectAt(c9 + 3, S_DEN,   "den_end",    32'h0);
        expectAt(c9 + 4, S_GRANT, "den_grant2", 32'h0);
        waitUntil(c9 + 5);
        applyStimulus(1, 3'b001, 3'd0);
        waitUntil(c9 + 7);
        applyStimulus(1, 3'b001, 3'd3);
        expectAt(c9 + 9,  S_DEN, "den_again",  32'h2);
        expectAt(c9 + 10, S_DEN, "den_again0", 32'h0);

        // Asynchronous reset mid-grant
        waitUntil(c9 + 14);
        c10 = cyc;
        applyStimulus(1, 3'b000, 3'd0);
        applyStimulus(0, 3'b100, 3'd7);
        expectAt(c10 + 2, S_GRANT, "pre_rst_grant", 32'h1);
        expectAt(c10 + 2, S_ACT,   "pre_rst_act",   32'h7);
        waitUntil(c10 + 6);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_grant", 32'(grant),   32'h0);
        checkOutput("arst_led",   32'(ledRgb),  32'h1);
        checkOutput("arst_act",   32'(actFunc), 32'h0);
        #3 reset = 1'b0;
        cr = cyc;
        expectAt(cr + 2, S_GRANT, "post_rst_grant", 32'h1);
        expectAt(cr + 2, S_LED,   "post_rst_led",   32'h2);

        waitUntil(cr + 6);
        checkOutput("sb_drain", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
